// File: rtl/des_round_engine_if.sv
// Block, key and handshake bundle between a data source/sink and des_round_engine.
// master = source/sink side, slave = engine side.
interface des_round_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic        decrypt;
  logic        tdes_mode;
  logic [63:0] block_in;
  logic [63:0] key1;
  logic [63:0] key2;
  logic [63:0] key3;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] block_out;
  logic        busy;

  modport master (
    output in_valid, decrypt, tdes_mode, block_in, key1, key2, key3, out_ready,
    input  in_ready, out_valid, block_out, busy
  );

  modport slave (
    input  in_valid, decrypt, tdes_mode, block_in, key1, key2, key3, out_ready,
    output in_ready, out_valid, block_out, busy
  );
endinterface

// File: rtl/des_round_engine.sv
// Iterative DES/3DES engine: ROUNDS_PER_CYCLE Feistel rounds per clock with an on-the-fly key schedule.
// 3DES (EDE) support, its pass counter and key2/key3 registers exist only when DES_ENGINE_TDES_EN is defined.

module des_sbox #(
  parameter int BOX = 0
) (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  // Rows of 16 nibbles, entry 0 in the top nibble; row = {addr[5], addr[0]}, column = addr[4:1].
  localparam logic [255:0] TABLE =
    (BOX == 0) ? 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D :
    (BOX == 1) ? 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9 :
    (BOX == 2) ? 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C :
    (BOX == 3) ? 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E :
    (BOX == 4) ? 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453 :
    (BOX == 5) ? 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D :
    (BOX == 6) ? 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C :
                 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  logic [5:0] idx;
  assign idx  = {addr[5], addr[0], addr[4:1]};
  assign data = TABLE[8'd255 - {idx, 2'b00} -: 4];
endmodule

module des_round_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  des_round_engine_if.slave bus
);
  localparam int RPC = ROUNDS_PER_CYCLE;

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [383:0] PC2_T = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32};
  localparam logic [255:0] P_T = {
    8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17, 8'd1,  8'd15, 8'd23, 8'd26,
    8'd5,  8'd18, 8'd31, 8'd10, 8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
    8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25};

  // DES numbers bits from 1 at the MSB, so source bit n of a W-bit word is word[W-n].
  function automatic int ip_src(input int i);
    return (((i / 8) < 4) ? 58 + 2 * (i / 8) : 49 + 2 * (i / 8)) - 8 * (i % 8);
  endfunction

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[63 - i] = x[64 - ip_src(i)];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[64 - ip_src(i)] = x[63 - i];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] y;
    int          src;
    y = 56'd0;
    for (int i = 0; i < 56; i++) begin
      if (i < 28)      src = 57 + i / 8 - 8 * (i % 8);
      else if (i < 52) src = 63 - (i - 28) / 8 - 8 * ((i - 28) % 8);
      else             src = 28 - 8 * (i - 52);
      y[55 - i] = k[64 - src];
    end
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[47 - i] = cd[56 - int'(PC2_T[383 - 8 * i -: 8])];
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] r);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[47 - i] = r[32 - (((4 * (i / 6) + (i % 6) + 31) % 32) + 1)];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] y;
    y = 32'd0;
    for (int i = 0; i < 32; i++) y[31 - i] = s[32 - int'(P_T[255 - 8 * i -: 8])];
    return y;
  endfunction

  // Decryption walks the schedule backwards: no shift before K16, then the encrypt shifts reversed.
  function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic dec);
    logic [1:0] sh;
    case (idx)
      4'd0:              sh = dec ? 2'd0 : 2'd1;
      4'd1, 4'd8, 4'd15: sh = 2'd1;
      default:           sh = 2'd2;
    endcase
    return sh;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] sh, input logic right);
    logic [27:0] y;
    case ({right, sh})
      3'b001:  y = {x[26:0], x[27]};
      3'b010:  y = {x[25:0], x[27:26]};
      3'b101:  y = {x[0], x[27:1]};
      3'b110:  y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, state_next_s;
  logic [31:0] l_r, r_r;
  logic [27:0] c_r, d_r;
  logic [3:0]  round_r;
  logic        dec_r;
  logic        out_valid_r;
  logic [63:0] block_out_r;
`ifdef DES_ENGINE_TDES_EN
  logic [1:0]  pass_r;
  logic        tdes_r;
  logic [63:0] key1_r, key2_r, key3_r;
  logic [63:0] next_key_s;
`endif

  logic        accept_s, pass_end_s, finish_s, dir_s;
  logic [4:0]  round_sum_s;
  logic [63:0] first_key_s, ip_s;
  logic [31:0] l_s [RPC+1];
  logic [31:0] r_s [RPC+1];
  logic [27:0] c_s [RPC+1];
  logic [27:0] d_s [RPC+1];

  assign accept_s      = bus.in_valid && (state_r == IDLE);
  assign ip_s          = ip_perm(bus.block_in);
  assign bus.in_ready  = (state_r == IDLE);
  assign bus.busy      = (state_r == ROUND);
  assign bus.out_valid = out_valid_r;
  assign bus.block_out = block_out_r;

  // Pass bookkeeping: direction of the running pass, end-of-pass and end-of-block detection.
  always_comb begin
    round_sum_s = {1'b0, round_r} + 5'(RPC);
    pass_end_s  = round_sum_s[4];
`ifdef DES_ENGINE_TDES_EN
    dir_s       = dec_r ^ (pass_r == 2'd1);
    finish_s    = pass_end_s && (!tdes_r || (pass_r == 2'd2));
    first_key_s = (bus.tdes_mode && bus.decrypt) ? bus.key3 : bus.key1;
    next_key_s  = (pass_r == 2'd0) ? key2_r : (dec_r ? key1_r : key3_r);
`else
    dir_s       = dec_r;
    finish_s    = pass_end_s;
    first_key_s = bus.key1;
`endif
  end

  assign l_s[0] = l_r;
  assign r_s[0] = r_r;
  assign c_s[0] = c_r;
  assign d_s[0] = d_r;

  for (genvar j = 0; j < RPC; j++) begin : g_round
    logic [3:0]  idx_s;
    logic [1:0]  sh_s;
    logic [47:0] x_s;
    logic [31:0] sbox_s;

    assign idx_s    = round_r + 4'(j);
    assign sh_s     = shift_amt(idx_s, dir_s);
    assign c_s[j+1] = rot28(c_s[j], sh_s, dir_s);
    assign d_s[j+1] = rot28(d_s[j], sh_s, dir_s);
    assign x_s      = e_exp(r_s[j]) ^ pc2_perm({c_s[j+1], d_s[j+1]});

    for (genvar b = 0; b < 8; b++) begin : g_sbox
      des_sbox #(.BOX(b)) u_sbox (.addr(x_s[47 - 6 * b -: 6]), .data(sbox_s[31 - 4 * b -: 4]));
    end

    assign l_s[j+1] = r_s[j];
    assign r_s[j+1] = l_s[j] ^ p_perm(sbox_s);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (bus.in_valid) state_next_s = ROUND; else state_next_s = IDLE;
      ROUND:   if (finish_s) state_next_s = DONE; else state_next_s = ROUND;
      DONE:    if (out_valid_r && bus.out_ready) state_next_s = IDLE; else state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate rounds, chain 3DES passes, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_r         <= 32'd0;
      r_r         <= 32'd0;
      c_r         <= 28'd0;
      d_r         <= 28'd0;
      round_r     <= 4'd0;
      dec_r       <= 1'b0;
      out_valid_r <= 1'b0;
      block_out_r <= 64'd0;
`ifdef DES_ENGINE_TDES_EN
      pass_r      <= 2'd0;
      tdes_r      <= 1'b0;
      key1_r      <= 64'd0;
      key2_r      <= 64'd0;
      key3_r      <= 64'd0;
`endif
    end else if (accept_s) begin
      {l_r, r_r} <= ip_s;
      {c_r, d_r} <= pc1_perm(first_key_s);
      round_r    <= 4'd0;
      dec_r      <= bus.decrypt;
`ifdef DES_ENGINE_TDES_EN
      pass_r     <= 2'd0;
      tdes_r     <= bus.tdes_mode;
      key1_r     <= bus.key1;
      key2_r     <= bus.key2;
      key3_r     <= bus.key3;
`endif
    end else if (state_r == ROUND) begin
      round_r <= round_sum_s[3:0];
      if (finish_s) begin
        block_out_r <= fp_perm({r_s[RPC], l_s[RPC]});
        out_valid_r <= 1'b1;
`ifdef DES_ENGINE_TDES_EN
      end else if (pass_end_s) begin
        // FP then IP of the next pass cancel, leaving only the final swap.
        l_r        <= r_s[RPC];
        r_r        <= l_s[RPC];
        {c_r, d_r} <= pc1_perm(next_key_s);
        pass_r     <= pass_r + 2'd1;
`endif
      end else begin
        l_r <= l_s[RPC];
        r_r <= r_s[RPC];
        c_r <= c_s[RPC];
        d_r <= d_s[RPC];
      end
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: a known-answer vector table plus hold, reset, back-to-back and
// round-trip sequences, with one R=1 and one R=4 engine driven by the same stimulus.
module tb_des_round_engine;
`ifdef DES_ENGINE_TDES_EN
  localparam int LAT_T = 48;
`else
  localparam int LAT_T = 16;
`endif

  typedef struct {
    logic        dec;
    logic        tdes;
    logic [63:0] k1;
    logic [63:0] k2;
    logic [63:0] k3;
    logic [63:0] din;
    logic [63:0] dout;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        decrypt = 1'b0;
  logic        tdes_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] block_in = 64'd0;
  logic [63:0] key1 = 64'd0;
  logic [63:0] key2 = 64'd0;
  logic [63:0] key3 = 64'd0;
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs [10];

  des_round_engine_if bus1 ();
  des_round_engine_if bus4 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.decrypt   = decrypt;
  assign bus1.tdes_mode = tdes_mode;
  assign bus1.block_in  = block_in;
  assign bus1.key1      = key1;
  assign bus1.key2      = key2;
  assign bus1.key3      = key3;
  assign bus1.out_ready = out_ready;
  assign bus4.in_valid  = in_valid;
  assign bus4.decrypt   = decrypt;
  assign bus4.tdes_mode = tdes_mode;
  assign bus4.block_in  = block_in;
  assign bus4.key1      = key1;
  assign bus4.key2      = key2;
  assign bus4.key3      = key3;
  assign bus4.out_ready = out_ready;

  des_round_engine #(.ROUNDS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  des_round_engine #(.ROUNDS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    decrypt   = v.dec;
    tdes_mode = v.tdes;
    key1      = v.k1;
    key2      = v.k2;
    key3      = v.k3;
    block_in  = v.din;
  endtask

  task automatic start_block(input vec_t v);
    int n;
    n = 0;
    while (!bus1.in_ready && n < 100) begin
      step();
      n++;
    end
    check("in_ready_before_accept", 64'(bus1.in_ready), 64'd1);
    drive(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat1, output int lat4);
    lat1 = -1;
    lat4 = -1;
    for (int c = 0; c < 200; c++) begin
      if (bus4.out_valid && lat4 < 0) lat4 = c;
      if (bus1.out_valid) begin
        lat1 = c;
        break;
      end
      step();
    end
  endtask

  task automatic finish_block();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_handshake", {62'd0, bus1.out_valid, bus4.out_valid}, 64'd0);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit chk, output logic [63:0] res);
    int l1, l4;
    start_block(v);
    wait_done(l1, l4);
    check({tag, "_lat_r1"}, 64'(l1), 64'(v.lat));
    check({tag, "_lat_r4"}, 64'(l4), 64'(v.lat / 4));
    if (chk) begin
      check({tag, "_out_r1"}, bus1.block_out, v.dout);
      check({tag, "_out_r4"}, bus4.block_out, v.dout);
    end
    res = bus1.block_out;
    finish_block();
  endtask

  initial begin
    logic [63:0] res;
    int          l1, l4;
    bit          seen;
    vec_t        v;

    vecs[0] = '{1'b0, 1'b0, 64'h133457799BBCDFF1, 64'd0, 64'd0, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 16};
    vecs[1] = '{1'b1, 1'b0, 64'h133457799BBCDFF1, 64'd0, 64'd0, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 16};
    vecs[2] = '{1'b0, 1'b0, 64'h0E329232EA6D0D73, 64'd0, 64'd0, 64'h8787878787878787, 64'h0000000000000000, 16};
    vecs[3] = '{1'b1, 1'b0, 64'h0E329232EA6D0D73, 64'd0, 64'd0, 64'h0000000000000000, 64'h8787878787878787, 16};
    vecs[4] = '{1'b0, 1'b0, 64'h0000000000000000, 64'd0, 64'd0, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 16};
    vecs[5] = '{1'b1, 1'b0, 64'h0000000000000000, 64'd0, 64'd0, 64'h8CA64DE9C1B123A7, 64'h0000000000000000, 16};
    vecs[6] = '{1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 16};
    vecs[7] = '{1'b0, 1'b1, 64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 64'h133457799BBCDFF1,
                64'h0123456789ABCDEF, 64'h85E813540F0AB405, LAT_T};
    vecs[8] = '{1'b1, 1'b1, 64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 64'h133457799BBCDFF1,
                64'h85E813540F0AB405, 64'h0123456789ABCDEF, LAT_T};
    vecs[9] = '{1'b0, 1'b0, 64'h133457799BBCDFF1, 64'h0E329232EA6D0D73, 64'h0E329232EA6D0D73,
                64'h0123456789ABCDEF, 64'h85E813540F0AB405, 16};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_in_ready", {62'd0, bus1.in_ready, bus4.in_ready}, 64'd3);
    check("reset_out_valid", {62'd0, bus1.out_valid, bus4.out_valid}, 64'd0);
    check("reset_busy", {62'd0, bus1.busy, bus4.busy}, 64'd0);
    check("reset_block_out", bus1.block_out, 64'd0);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b1, res);

    // One-cycle reset on the 7th round edge aborts the block.
    start_block(vecs[0]);
    for (int c = 0; c < 6; c++) step();
    check("mid_busy", {62'd0, bus1.busy, bus1.in_ready}, 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 64'(bus1.in_ready), 64'd1);
    check("abort_busy", 64'(bus1.busy), 64'd0);
    check("abort_out_valid", {62'd0, bus1.out_valid, bus4.out_valid}, 64'd0);
    check("abort_block_out", bus1.block_out, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus1.out_valid) seen = 1'b1;
      step();
    end
    check("abort_no_output", 64'(seen), 64'd0);
    run_vec("after_abort", vecs[0], 1'b1, res);

    // Result must hold while the consumer stalls.
    start_block(vecs[2]);
    wait_done(l1, l4);
    check("hold_lat", 64'(l1), 64'd16);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold%0d_block_out", c), bus1.block_out, vecs[2].dout);
      check($sformatf("hold%0d_valid_ready", c), {62'd0, bus1.out_valid, bus1.in_ready}, 64'd2);
      step();
    end
    finish_block();

    // Back-to-back: second block waits behind the output handshake; in_valid/inputs churn meanwhile.
    check("b2b_in_ready", 64'(bus1.in_ready), 64'd1);
    drive(vecs[0]);
    in_valid = 1'b1;
    step();
    drive(vecs[4]);
    l1 = -1;
    for (int c = 0; c < 100; c++) begin
      if (bus1.out_valid) begin
        l1 = c;
        break;
      end
      in_valid = ~in_valid;
      step();
    end
    in_valid = 1'b1;
    check("b2b_first_lat", 64'(l1), 64'd16);
    check("b2b_first_out_r1", bus1.block_out, vecs[0].dout);
    check("b2b_first_out_r4", bus4.block_out, vecs[0].dout);
    step();
    check("b2b_done_not_ready", {62'd0, bus1.in_ready, bus4.in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("b2b_idle_after_hs", {62'd0, bus1.in_ready, bus1.busy}, 64'd2);
    step();
    in_valid = 1'b0;
    check("b2b_second_accepted", {62'd0, bus1.in_ready, bus1.busy}, 64'd1);
    wait_done(l1, l4);
    check("b2b_second_lat", 64'(l1), 64'd16);
    check("b2b_second_out_r1", bus1.block_out, vecs[4].dout);
    check("b2b_second_out_r4", bus4.block_out, vecs[4].dout);
    finish_block();

    // Three distinct keys: encrypt then decrypt must return the plaintext.
    v = '{1'b0, 1'b1, 64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123,
          64'h5468652071756663, 64'd0, LAT_T};
    run_vec("rt_enc", v, 1'b0, res);
    v.dec  = 1'b1;
    v.din  = res;
    v.dout = 64'h5468652071756663;
    run_vec("rt_dec", v, 1'b1, res);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/des_round_engine.md
Name: des_round_engine

Overview:
Iterative DES/3DES block cipher core with an internal key schedule, IP/FP permutations and a valid/ready handshake on both sides. It accepts one 64-bit block, computes ROUNDS_PER_CYCLE Feistel rounds per clock and presents the result until the consumer accepts it. It sits between the USB data path and the encryptor controller, and is the parametrised successor of the single-round computation block.

Parameters:
ROUNDS_PER_CYCLE, 1, Feistel rounds unrolled per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  block_in, keys and mode are valid
in_ready  output  1  engine can accept a block (high only in IDLE)
decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on accept
tdes_mode  input  1  1 = 3DES EDE, 0 = single DES; sampled on accept
block_in  input  64  plaintext/ciphertext, bit 63 = DES bit 1
key1  input  64  DES key 1, parity bits ignored
key2  input  64  DES key 2, used only in 3DES
key3  input  64  DES key 3, used only in 3DES
out_valid  output  1  block_out holds a result
out_ready  input  1  consumer accepts block_out
block_out  output  64  result block
busy  output  1  high in ROUND state

Behaviour:
- Reset (rst=1 at a rising edge): state = IDLE, out_valid = 0, block_out = 0, busy = 0, round and pass counters = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-operation aborts the block. No output is produced and the engine returns to IDLE.
- States: IDLE -> ROUND on accept (in_valid & in_ready). ROUND -> DONE after the final round. DONE -> IDLE on out_valid & out_ready.
- in_ready is combinational: it equals (state == IDLE). in_ready is never high in DONE, so there is no overlap of blocks.
- Accept edge actions:
  - L,R <= IP(block_in).
  - C,D <= PC1(first key of the pass).
  - decrypt, tdes_mode, key1, key2 and key3 are registered; later input changes are ignored.
- ROUND, each cycle:
  - Apply ROUNDS_PER_CYCLE chained rounds: L' = R, R' = L ^ P(S(E(R) ^ Kn)).
  - The S-box lookup uses the team's des_sbox module, 8 instances per round.
  - Round counter advances by ROUNDS_PER_CYCLE, modulo 16.
- Key schedule, encrypt: left-rotate C,D by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, then apply PC2.
- Key schedule, decrypt: use PC2 of C,D rotated right by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. This yields K16..K1.
- Pass end (16 rounds done):
  - Final swap: block = {R16, L16}.
  - Single DES: block_out <= FP({R16, L16}), out_valid <= 1, state -> DONE.
  - 3DES, pass 0 or 1: L <= R16, R <= L16 (FP followed by IP cancels). C,D reload from PC1 of the next key on the same edge. Pass counter increments and the engine stays in ROUND.
- 3DES key and direction order:
  - Encrypt: E(key1), D(key2), E(key3).
  - Decrypt: D(key3), E(key2), D(key1).
- Latency, accept edge to out_valid high: 16/ROUNDS_PER_CYCLE cycles for DES, 48/ROUNDS_PER_CYCLE cycles for 3DES.
- DONE: block_out and out_valid hold stable while out_ready = 0. When out_valid & out_ready at an edge: out_valid <= 0 and state -> IDLE. block_out keeps its value until the next result.
- out_ready high outside DONE has no effect.
- in_valid high outside IDLE is ignored; the source must hold it until in_ready.

Optional Feature:
Macro DES_ENGINE_TDES_EN.
- Defined: 3DES behaviour as specified; pass counter and key2/key3 registers present.
- Undefined:
  - tdes_mode, key2 and key3 are ignored. No registers are built for them.
  - Every block is single DES with key1.
  - The pass counter is removed.

Test Plan:
- ROUNDS_PER_CYCLE=1, encrypt, key1=133457799BBCDFF1, block_in=0123456789ABCDEF -> block_out=85E813540F0AB405, out_valid rises exactly 16 cycles after the accept edge.
- Same key, decrypt, block_in=85E813540F0AB405 -> block_out=0123456789ABCDEF. Repeat with ROUNDS_PER_CYCLE=4 -> same result, latency 4 cycles.
- Encrypt, key1=0E329232EA6D0D73, block_in=8787878787878787 -> block_out=0000000000000000. Hold out_ready=0 for 10 cycles -> block_out and out_valid stable, in_ready=0 throughout.
- With DES_ENGINE_TDES_EN: tdes_mode=1, key1=key2=key3=133457799BBCDFF1, block_in=0123456789ABCDEF -> 85E813540F0AB405 after 48 cycles (R=1). Random K1≠K2≠K3: encrypt then decrypt round-trips to the original block.
- Assert rst for 1 cycle during ROUND (cycle 7 of 16) -> out_valid never asserts, in_ready=1 the next cycle, and the following block completes correctly.
- Back-to-back: in_valid held high with two blocks queued -> second accepted only on the cycle after the out_valid & out_ready handshake. in_valid toggling during ROUND does not change the result.
